// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, sync pulses and per-line/per-frame
// strobes, all registered from the next counter values so every output shares one edge.
module vga_timing #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0,
    parameter int   CLK_DIV    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_stb,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       h_sync,
    output logic       v_sync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_field_check
        $error("vga_timing: every timing field must be non-zero");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
        $error("vga_timing: CLK_DIV must be within 1..16");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       new_line;
    logic       new_frame;
    logic       new_vblank;

    // With CLK_DIV=1 div never leaves 0, so the strobe decodes to a constant 1.
    assign pix_stb = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (pix_stb) begin
            div <= '0;
        end else begin
            div <= div + 4'd1;
        end
    end

    always_comb begin
        x_next = pix_x;
        y_next = pix_y;
        if (pix_stb) begin
            if (pix_x == H_LAST) begin
                x_next = '0;
                y_next = (pix_y == V_LAST) ? 10'd0 : pix_y + 10'd1;
            end else begin
                x_next = pix_x + 10'd1;
            end
        end
    end

    // Pulses only fire on an advancing edge, so they stay one clk wide for any divider.
    assign new_line   = pix_stb && (x_next == 10'd0);
    assign new_frame  = new_line && (y_next == 10'd0);
    assign new_vblank = new_line && (y_next == V_VIS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x        <= H_LAST;
            pix_y        <= V_LAST;
            h_sync       <= ~H_SYNC_POL;
            v_sync       <= ~V_SYNC_POL;
            display_on   <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            pix_x        <= x_next;
            pix_y        <= y_next;
            h_sync       <= (x_next >= HS_START && x_next < HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync       <= (y_next >= VS_START && y_next < VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
            display_on   <= (x_next < H_VIS) && (y_next < V_VIS);
            line_start   <= new_line;
            frame_start  <= new_frame;
            vblank_start <= new_vblank;
            if (new_vblank) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates the raster timing for the game's VGA output. Provides the pixel/line counters (`pix_x`, `pix_y`), the sync pulses and `display_on` that every sprite renderer and the pixel mixer consume. `v_sync` is also used directly as the per-frame update clock by the movement logic. All outputs are registered and mutually aligned, so any sprite block sees a consistent (x, y, sync) tuple in every clock cycle.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_SYNC_POL`, 0, asserted level of `h_sync` (0 = active-low)
- `V_SYNC_POL`, 0, asserted level of `v_sync` (0 = active-low)
- `CLK_DIV`, 1, `clk` cycles per pixel (1..16)

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `pix_stb`  out  1  high in cycles where the counters advance at the next edge
- `pix_x`  out  10  current horizontal position, 0..H_TOTAL-1
- `pix_y`  out  10  current vertical position, 0..V_TOTAL-1
- `h_sync`  out  1  horizontal sync
- `v_sync`  out  1  vertical sync
- `display_on`  out  1  high when (pix_x, pix_y) is in the active area
- `line_start`  out  1  1-clk pulse when pix_x becomes 0
- `frame_start`  out  1  1-clk pulse when (pix_x, pix_y) becomes (0, 0)
- `vblank_start`  out  1  1-clk pulse when (pix_x, pix_y) becomes (0, V_ACTIVE)
- `frame_count`  out  8  frames completed, increments with `vblank_start`

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Elaboration error if either total exceeds 1024, if any field is 0, or if CLK_DIV is outside 1..16.
- Divider: `div` counts 0..CLK_DIV-1 and wraps. `pix_stb` = (div == CLK_DIV-1), decoded from the register. For CLK_DIV=1, `pix_stb` is constant 1.
- On an edge where `pix_stb` is high:
  - pix_x increments; at H_TOTAL-1 it wraps to 0 and pix_y increments.
  - pix_y wraps from V_TOTAL-1 to 0.
- `h_sync` is asserted iff H_ACTIVE+H_FP ≤ pix_x < H_ACTIVE+H_FP+H_SYNC (656..751).
- `v_sync` is asserted iff V_ACTIVE+V_FP ≤ pix_y < V_ACTIVE+V_FP+V_SYNC (490..491).
- Inactive sync level = ~POL.
- `display_on` = pix_x < H_ACTIVE && pix_y < V_ACTIVE.
- Sync, `display_on` and the pulses are flops loaded from the *next* counter values, so they change on the same edge as pix_x/pix_y. There is zero skew, and no combinational path reaches `h_sync`/`v_sync`, which keeps them glitch-free for use as a clock.
- Pulses are high for exactly one `clk` cycle (the first cycle of the new position), regardless of CLK_DIV.
- `frame_count` is 8-bit modulo and wraps 255→0.

## Timing
- Reset (asynchronous, takes effect immediately regardless of `clk`):
  - div=0
  - pix_x=H_TOTAL-1 (799), pix_y=V_TOTAL-1 (524)
  - display_on=0; h_sync, v_sync inactive
  - line_start, frame_start, vblank_start = 0
  - frame_count=0
- Edges after release are numbered 1, 2, …. The first counter advance occurs at edge CLK_DIV, giving (0,0) with display_on=1, frame_start=1 and line_start=1.
- Reset asserted mid-frame: outputs return to reset values asynchronously. After release the raster restarts at (0,0) per the rule above, and no partial pulse is emitted.
- Period: line = H_TOTAL·CLK_DIV clks; frame = H_TOTAL·V_TOTAL·CLK_DIV clks (420000 at defaults).
- `pix_x`/`pix_y` latency from `pix_stb`: 1 edge.

## Test plan
- Reset hold with CLK_DIV=1: expect (799,524), display_on=0, h_sync=v_sync=1, frame_count=0. After release, edge 1 gives (0,0), display_on=1, frame_start=line_start=1 for 1 clk, then 0.
- One line at defaults: display_on drops at pix_x=640; h_sync is low for pix_x 656..751 (exactly 96 clks); line_start repeats every 800 clks.
- One frame at defaults:
  - v_sync is low for pix_y 490..491 (1600 clks, edges aligned with pix_x=0).
  - vblank_start fires at (0,480) and frame_count goes 0→1.
  - Next frame_start arrives 420000 clks after the first.
- CLK_DIV=2: pix_stb alternates 0/1 starting at 0; each pix_x value is held 2 clks; frame = 840000 clks; pulses stay 1 clk wide.
- Small-timing override (H 8/1/2/1, V 4/1/1/1, POL=1): h_sync high at pix_x 9..10 only; frame_count wraps 255→0 on the 256th vblank_start.
- Asynchronous reset asserted at (300,200) between clock edges: outputs show reset values before the next edge. After release, the first advance gives (0,0) with frame_start=1 and frame_count=0.
